// File: rtl/sll_iter_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_pkg
// Purpose  : Shared definitions for the iterative logical-left shifter:
//            datapath widths, the controller state encoding and the check
//            that decides which per-cycle step sizes are supported.
// Contents : XLEN, SHAMT_W, state_t, LEGAL_STEP_MASK, is_legal_step()
// Revision : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    // Operand width and the width of a shift distance that covers it.
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // Controller states. Two bits are enough; the fourth code is unused and
    // recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One bit per step size: bit N set means a step of N positions per
    // cycle is supported. Only powers of two up to 16 qualify, so the
    // barrel inside sll_step stays a clean log2 ladder.
    localparam logic [31:0] LEGAL_STEP_MASK = 32'h0001_0116;

    // Elaboration-time helper used to reject an unsupported step size.
    function automatic logic is_legal_step(input int step);
        logic [4:0] idx;
        idx = step[4:0];
        if (step < 1 || step > 31) begin
            return 1'b0;
        end
        return LEGAL_STEP_MASK[idx];
    endfunction

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/sll_iter_shifter_step.sv
`default_nettype none
// ============================================================================
// Module   : sll_step
// Purpose  : Combinational left shift by 0..STEP positions with zero fill.
//            Built as a log2(STEP)+1 stage ladder; stage k shifts by 2^k
//            when bit k of the amount is set. Bits shifted past the MSB
//            are discarded.
// Ports    : acc    in  XLEN   value to shift
//            amt    in  AMT_W  shift distance, 0..STEP
//            result out XLEN   acc << amt
// Revision : 1.0 - initial release
// ============================================================================
module sll_step
    import shifter_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(STEP) + 1
) (
    input  logic [XLEN-1:0]  acc,
    input  logic [AMT_W-1:0] amt,
    output logic [XLEN-1:0]  result
);

    // w_stage[k] holds the value after the first k ladder stages.
    logic [XLEN-1:0] w_stage [AMT_W+1];

    assign w_stage[0] = acc;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        assign w_stage[k+1] = amt[k] ? (w_stage[k] << (1 << k)) : w_stage[k];
    end

    assign result = w_stage[AMT_W];

endmodule : sll_step
`default_nettype wire

// File: rtl/sll_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sll_iter_shifter
// Purpose  : Multicycle logical-left shifter. A request carries a 32-bit
//            operand and a 5-bit distance; the unit shifts by at most STEP
//            positions per clock and presents (data_in << shift_amount)
//            mod 2^32 on a valid/ready response port.
// Ports    : clk           in   clock, rising edge
//            rst_n         in   synchronous active-low reset
//            in_valid      in   request valid
//            in_ready      out  request accepted when high (IDLE only)
//            data_in       in   operand, sampled on request handshake
//            shift_amount  in   distance 0..31, sampled on handshake
//            out_valid     out  result valid (DONE only)
//            out_ready     in   consumer takes the result
//            data_out      out  accumulator contents
//            busy          out  high in SHIFT or DONE
// Revision : 1.0 - initial release
// ============================================================================
module sll_iter_shifter
    import shifter_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] shift_amount,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    data_out,
    output logic               busy
);

    // Width of a per-cycle shift distance: must hold the value STEP itself.
    localparam int AMT_W = $clog2(STEP) + 1;

    if (!is_legal_step(STEP)) begin : g_step_check
        $error("sll_iter_shifter: STEP=%0d is not one of 1, 2, 4, 8, 16", STEP);
    end

    state_t             r_state;
    logic [XLEN-1:0]    r_acc;
    logic [SHAMT_W-1:0] r_rem;

    logic [AMT_W-1:0]   w_amt;
    logic [SHAMT_W-1:0] w_rem_next;
    logic [XLEN-1:0]    w_shifted;

    // Take a full step while enough distance remains, otherwise finish off
    // the remainder in one go. When rem < STEP the remainder fits in AMT_W
    // bits, so the slice below loses nothing.
    assign w_amt      = (r_rem < SHAMT_W'(STEP)) ? r_rem[AMT_W-1:0] : AMT_W'(STEP);
    assign w_rem_next = r_rem - SHAMT_W'(w_amt);

    sll_step #(
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .acc    (r_acc),
        .amt    (w_amt),
        .result (w_shifted)
    );

    // The accumulator is the output register; it is left untouched in DONE
    // so the result stays stable under backpressure.
    assign data_out = r_acc;

    // Controller. in_ready/out_valid/busy are registered together with the
    // next state so they are always a pure function of the state register
    // and never see in_valid or out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_rem     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc    <= data_in;
                        r_rem    <= shift_amount;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (shift_amount == '0) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            r_state   <= SHIFT;
                            out_valid <= 1'b0;
                        end
                    end
                end

                SHIFT: begin
                    r_acc <= w_shifted;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // No bypass to IDLE-accept in the same cycle: a new
                    // request can only be taken one cycle after this.
                    if (out_ready) begin
                        r_state   <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_rem     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : sll_iter_shifter
`default_nettype wire

// File: tb/tb_sll_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sll_iter_shifter
// Purpose  : Self-checking bench for sll_iter_shifter. One instance per
//            supported step size (1, 2, 4, 8, 16), each with its own
//            handshake signals; directed vectors with hand-computed results
//            plus a short randomised pass checked against data << shift.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sll_iter_shifter;

    localparam int NDUT = 5;
    localparam int STEPS [NDUT] = '{1, 2, 4, 8, 16};
    localparam int MAX_WAIT = 64;

    logic        clk;
    logic        rst_n        [NDUT];
    logic        in_valid     [NDUT];
    logic        in_ready     [NDUT];
    logic [31:0] data_in      [NDUT];
    logic [4:0]  shift_amount [NDUT];
    logic        out_valid    [NDUT];
    logic        out_ready    [NDUT];
    logic [31:0] data_out     [NDUT];
    logic        busy         [NDUT];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sll_iter_shifter #(
            .STEP (STEPS[g])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .data_in      (data_in[g]),
            .shift_amount (shift_amount[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .data_out     (data_out[g]),
            .busy         (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (at negedges) until out_valid of instance d rises; returns the
    // number of cycles since the accept cycle, or MAX_WAIT+1 on timeout.
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (out_valid[d] !== 1'b1 && lat <= MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One complete transaction on instance d. Called at a negedge.
    task automatic run_op(input int d, input logic [31:0] din, input logic [4:0] sh,
                          input logic [31:0] exp_val, input int exp_lat,
                          input int pre_idle, input int hold, input string tag);
        int    lat;
        string t;
        t = $sformatf("s%0d_%s", STEPS[d], tag);
        repeat (pre_idle) @(negedge clk);
        in_valid[d]     = 1'b1;
        data_in[d]      = din;
        shift_amount[d] = sh;
        @(negedge clk);
        // Scramble the request inputs: the unit must have captured them.
        in_valid[d]     = 1'b0;
        data_in[d]      = ~din;
        shift_amount[d] = ~sh;
        wait_valid(d, lat);
        check({t, "_lat"}, 32'(lat), 32'(exp_lat));
        check({t, "_data"}, data_out[d], exp_val);
        repeat (hold) begin
            @(negedge clk);
            check({t, "_hold_data"}, data_out[d], exp_val);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check({t, "_idle_ready"}, 32'(in_ready[d]), 32'd1);
        check({t, "_idle_valid"}, 32'(out_valid[d]), 32'd0);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d]        = 1'b0;
            in_valid[d]     = 1'b0;
            data_in[d]      = 32'hFFFF_FFFF;
            shift_amount[d] = 5'd7;
            out_ready[d]    = 1'b0;
        end
        repeat (2) @(negedge clk);
        // Requests presented during reset must be ignored.
        for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0;
            rst_n[d]    = 1'b1;
        end

        // ---- reset state -------------------------------------------------
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("s%0d_rst_in_ready", STEPS[d]), 32'(in_ready[d]), 32'd1);
            check($sformatf("s%0d_rst_out_valid", STEPS[d]), 32'(out_valid[d]), 32'd0);
            check($sformatf("s%0d_rst_busy", STEPS[d]), 32'(busy[d]), 32'd0);
            check($sformatf("s%0d_rst_data", STEPS[d]), data_out[d], 32'h0000_0000);
        end

        // ---- directed vectors -------------------------------------------
        run_op(0, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 0, 0, "one_by_31");
        run_op(2, 32'h1234_5678, 5'd13, 32'h8ACF_0000, 5, 0, 0, "x1234_by_13");
        run_op(4, 32'h1234_5678, 5'd13, 32'h8ACF_0000, 2, 0, 0, "x1234_by_13");
        run_op(1, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 2, 0, 0, "ones_by_1");
        run_op(3, 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000, 3, 0, 0, "a5_by_16");
        run_op(4, 32'hCAFE_F00D, 5'd16, 32'hF00D_0000, 2, 0, 0, "cafe_by_16");
        run_op(4, 32'h0000_0003, 5'd31, 32'h8000_0000, 3, 0, 0, "three_by_31");

        // ---- zero shift: latency 1, busy for exactly one cycle ----------
        in_valid[0]     = 1'b1;
        data_in[0]      = 32'hDEAD_BEEF;
        shift_amount[0] = 5'd0;
        out_ready[0]    = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        data_in[0]  = 32'h0;
        check("s1_zero_valid", 32'(out_valid[0]), 32'd1);
        check("s1_zero_busy", 32'(busy[0]), 32'd1);
        check("s1_zero_data", data_out[0], 32'hDEAD_BEEF);
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("s1_zero_busy_after", 32'(busy[0]), 32'd0);
        check("s1_zero_ready_after", 32'(in_ready[0]), 32'd1);

        // ---- backpressure with a competing request ----------------------
        in_valid[2]     = 1'b1;
        data_in[2]      = 32'h0000_00A5;
        shift_amount[2] = 5'd4;
        @(negedge clk);
        data_in[2]      = 32'h0F0F_0000;
        shift_amount[2] = 5'd3;
        wait_valid(2, lat);
        check("s4_bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 10; i++) begin
            check("s4_bp_valid", 32'(out_valid[2]), 32'd1);
            check("s4_bp_data", data_out[2], 32'h0000_0A50);
            check("s4_bp_in_ready", 32'(in_ready[2]), 32'd0);
            @(negedge clk);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        check("s4_bp_bubble_ready", 32'(in_ready[2]), 32'd1);
        check("s4_bp_bubble_valid", 32'(out_valid[2]), 32'd0);
        check("s4_bp_bubble_data", data_out[2], 32'h0000_0A50);
        @(negedge clk);
        in_valid[2] = 1'b0;
        wait_valid(2, lat);
        check("s4_bp2_lat", 32'(lat), 32'd2);
        check("s4_bp2_data", data_out[2], 32'h7878_0000);
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;

        // ---- reset in the middle of a shift -----------------------------
        in_valid[0]     = 1'b1;
        data_in[0]      = 32'h0000_0001;
        shift_amount[0] = 5'd20;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("s1_mid_busy", 32'(busy[0]), 32'd1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check("s1_mid_rst_ready", 32'(in_ready[0]), 32'd1);
        check("s1_mid_rst_valid", 32'(out_valid[0]), 32'd0);
        check("s1_mid_rst_busy", 32'(busy[0]), 32'd0);
        check("s1_mid_rst_data", data_out[0], 32'h0000_0000);
        run_op(0, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 9, 0, 0, "after_rst");

        // ---- randomised pass against data << shift ----------------------
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 150; i++) begin
                logic [31:0] din;
                logic [4:0]  sh;
                din = $urandom;
                sh  = 5'($urandom_range(0, 31));
                run_op(d, din, sh, din << sh, 1 + (int'(sh) + STEPS[d] - 1) / STEPS[d],
                       $urandom_range(0, 2), $urandom_range(0, 3), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sll_iter_shifter
`default_nettype wire

// File: doc/sll_iter_shifter.md
# sll_iter_shifter

Iterative logical-left shifter for the execute stage's multicycle shift path; it is the left-direction counterpart of the combinational arithmetic-right barrel shifter. It accepts a 32-bit operand and a 5-bit shift amount over a valid/ready request, shifts left by up to STEP bit positions per clock, and returns the result over a valid/ready response. It trades the full barrel-shifter mux tree for latency, and is meant for area-constrained builds and for SLL/SLLI.

## Interface
- STEP, 1: maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- data_in  in  32  operand; sampled on request handshake.
- shift_amount  in  5  left shift distance 0..31; sampled on request handshake.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- data_out  out  32  shifted result, driven from the accumulator register.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, the unit loads acc<=data_in and rem<=shift_amount. The next state is DONE if shift_amount==0, otherwise SHIFT.
- SHIFT: each cycle, amt = (rem < STEP) ? rem : STEP. The unit updates acc <= acc << amt (zero fill; MSBs discarded) and rem <= rem - amt. When rem - amt == 0, the next state is DONE.
- DONE: out_valid=1 and data_out=acc. On out_ready, the next state is IDLE. Otherwise the unit holds; data_out stays stable.
- in_valid outside IDLE is ignored. No request is queued.
- Result always equals (data_in << shift_amount) mod 2^32.
- Reset (rst_n=0 at a clock edge, in any state including mid-SHIFT): the unit goes to IDLE with acc=0 and rem=0. The in-flight operation is dropped silently.
- Reset values: in_ready=1, out_valid=0, busy=0, data_out=0x0000_0000.

## Timing
- Request accepted in cycle C0 (handshake at the edge ending C0).
- out_valid is first high in cycle C0 + 1 + ceil(shift_amount/STEP).
- shift_amount=0 gives a latency of 1.
- Worst case STEP=1, shift 31: latency 32. Worst case STEP=16, shift 31: latency 3.
- Response handshake at the edge ending cycle D leads to IDLE in D+1. in_ready is high in D+1. Back-to-back throughput therefore has a 1-cycle bubble; there is no same-cycle response-to-request bypass.
- in_ready, out_valid and busy are pure functions of the state register. No combinational path exists from in_valid or out_ready to any output.

## Structure
- Package shifter_pkg holds:
  - XLEN=32 and SHAMT_W=5;
  - the state enum typedef {IDLE, SHIFT, DONE};
  - the legal-STEP check constant.
- Sub-module sll_step (combinational) takes acc[31:0] and amt[$clog2(STEP):0] and returns acc<<amt. It is a log2(STEP)+1 stage barrel of left shifts with zero fill.
- The top level holds the FSM, acc, rem and the handshake logic.
- An elaboration-time assertion rejects an illegal STEP.

## Test plan
- STEP=1, data_in=0x0000_0001, shift_amount=31 -> data_out=0x8000_0000, out_valid first high 32 cycles after the accept cycle.
- STEP=1, data_in=0xDEAD_BEEF, shift_amount=0 -> data_out=0xDEAD_BEEF, out_valid in the cycle right after accept, busy high for exactly that cycle with out_ready=1.
- STEP=4, data_in=0x1234_5678, shift_amount=13 -> data_out=0x8ACF_0000, latency 5. STEP=16, same stimulus -> same result, latency 2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new operand -> out_valid and data_out stay stable, in_ready=0, and the second request is accepted only after the response handshake.
- Reset mid-op: STEP=1, shift 20, assert rst_n=0 for one edge after 5 SHIFT cycles -> next cycle in_ready=1, out_valid=0, data_out=0. A following request of 0x0000_00FF shifted by 8 returns 0x0000_FF00.
- Random regression: 10k random (data_in, shift_amount) pairs for each legal STEP with random in_valid/out_ready -> every response equals the scoreboard's data_in<<shift_amount, and every latency matches 1+ceil(shift/STEP).
